// File: rtl/calc_seq_ctrl.sv
// Calculator front-end controller: synchronises and debounces the push-buttons,
// captures the ALU op select and issues one accumulator write/clear per press.
module calc_seq_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btnu,
    input  logic       btnd,
    input  logic       btnl,
    input  logic       btnc,
    input  logic       btnr,
    output logic [2:0] op_sel,
    output logic       acc_we,
    output logic       acc_clr,
    output logic       busy
);

    localparam int unsigned CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned BTN_W   = 5;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DBNC = 2'd1,
        FIRE = 2'd2,
        HOLD = 2'd3
    } state_t;

    typedef enum logic {
        CMD_CLR = 1'b0,
        CMD_EXE = 1'b1
    } cmd_t;

    // Synchroniser stages, bit order {u, d, l, c, r}
    logic [BTN_W-1:0] sync1_q;
    logic [BTN_W-1:0] sync2_q;

    logic s_btnu;
    logic s_btnd;
    logic [2:0] s_op;

    state_t           state_q, state_d;
    cmd_t             cmd_q, cmd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_sel_d;
    logic             acc_we_d;
    logic             acc_clr_d;
    logic             busy_d;
    logic             sel_btn;

    assign s_btnu = sync2_q[4];
    assign s_btnd = sync2_q[3];
    assign s_op   = sync2_q[2:0];

    // Two-flop synchroniser for the asynchronous button inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {btnu, btnd, btnl, btnc, btnr};
            sync2_q <= sync1_q;
        end
    end

    // State, command, counter and registered output flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cmd_q   <= CMD_CLR;
            cnt_q   <= '0;
            op_sel  <= '0;
            acc_we  <= 1'b0;
            acc_clr <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            cnt_q   <= cnt_d;
            op_sel  <= op_sel_d;
            acc_we  <= acc_we_d;
            acc_clr <= acc_clr_d;
            busy    <= busy_d;
        end
    end

    // Next-state, counter, op capture and output decode
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        cnt_d    = cnt_q;
        op_sel_d = op_sel;
        sel_btn  = (cmd_q == CMD_CLR) ? s_btnu : s_btnd;

        unique case (state_q)
            IDLE: begin
                if (s_btnu) begin
                    state_d = DBNC;
                    cmd_d   = CMD_CLR;
                    cnt_d   = '0;
                end else if (s_btnd) begin
                    state_d = DBNC;
                    cmd_d   = CMD_EXE;
                    cnt_d   = '0;
                end
            end
            DBNC: begin
                if (!sel_btn) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if ((cmd_q == CMD_EXE) && s_btnu) begin
                    cmd_d = CMD_CLR;
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = FIRE;
                    if (cmd_q == CMD_EXE) begin
                        op_sel_d = s_op;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FIRE: begin
                state_d = HOLD;
                cnt_d   = '0;
            end
            HOLD: begin
                if (s_btnu || s_btnd) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Strobes follow the state being entered so they line up with FIRE
        acc_we_d  = (state_d == FIRE) && (cmd_d == CMD_EXE);
        acc_clr_d = (state_d == FIRE) && (cmd_d == CMD_CLR);
        busy_d    = (state_d != IDLE);
    end

endmodule
